// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL bit positions
// and the packed CTRL flag layout.
package timer_pkg;

  localparam int unsigned OFF_COUNT = 0;
  localparam int unsigned OFF_LIMIT = 4;
  localparam int unsigned OFF_CTRL  = 8;

  localparam int unsigned CTRL_READY = 0;
  localparam int unsigned CTRL_EN    = 1;
  localparam int unsigned CTRL_OVF   = 2;
  localparam int unsigned CTRL_IE    = 3;

  localparam int unsigned CTRL_WIDTH = 4;

  // Member order places ready at bit 0, matching the CTRL_* indices.
  typedef struct packed {
    logic ie;
    logic ovf;
    logic en;
    logic ready;
  } ctrl_t;

  typedef enum logic [1:0] {
    RegNone,
    RegCount,
    RegLimit,
    RegCtrl
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input int unsigned off);
    reg_sel_e sel;
    sel = RegNone;
    if (off == OFF_COUNT) sel = RegCount;
    else if (off == OFF_LIMIT) sel = RegLimit;
    else if (off == OFF_CTRL) sel = RegCtrl;
    return sel;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, COUNT/LIMIT/CTRL registers and the tick/wrap
// logic with sticky READY/OVF flags.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned BITS        = 32,
  parameter int unsigned TICK_CYCLES = 25000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_count_i,
  input  logic            we_limit_i,
  input  logic            we_ctrl_i,
  input  logic [BITS-1:0] wdata_i,
  output logic [BITS-1:0] count_o,
  output logic [BITS-1:0] limit_o,
  output logic [BITS-1:0] ctrl_o,
  output logic            irq_o
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [BITS-1:0] ONE = BITS'(1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [BITS-1:0] count_q, count_d;
  logic [BITS-1:0] limit_q, limit_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic tick;
  logic wrap_hit;
  logic wrap;

  assign tick = ctrl_q.en && (presc_q == PRESC_MAX);

  // LIMIT==0 makes limit-1 all-ones, so the free-running wrap and the
  // above-limit wrap at 2^BITS both fall out of the same compare.
  assign wrap_hit = (count_q == (limit_q - ONE)) || (&count_q);

  // A COUNT write on a tick edge wins and suppresses the READY set.
  assign wrap = tick && wrap_hit && !we_count_i;

  always_comb begin
    presc_d = presc_q;
    if (we_count_i || we_ctrl_i) begin
      presc_d = '0;
    end else if (ctrl_q.en) begin
      presc_d = tick ? '0 : presc_q + PRESC_ONE;
    end
  end

  always_comb begin
    count_d = count_q;
    if (we_count_i) begin
      count_d = wdata_i;
    end else if (tick) begin
      count_d = wrap_hit ? '0 : count_q + ONE;
    end
  end

  always_comb begin
    limit_d = limit_q;
    if (we_limit_i) begin
      limit_d = wdata_i;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (we_ctrl_i) begin
      ctrl_d.en    = wdata_i[CTRL_EN];
      ctrl_d.ie    = wdata_i[CTRL_IE];
      ctrl_d.ready = ctrl_q.ready & wdata_i[CTRL_READY];
      ctrl_d.ovf   = ctrl_q.ovf & wdata_i[CTRL_OVF];
    end
    // Set wins over a same-edge clear; OVF looks at READY before the write.
    if (wrap) begin
      ctrl_d.ready = 1'b1;
      if (ctrl_q.ready) begin
        ctrl_d.ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      count_q <= '0;
      limit_q <= '0;
      ctrl_q  <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      limit_q <= limit_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign count_o = count_q;
  assign limit_o = limit_q;
  assign ctrl_o  = {{(BITS - CTRL_WIDTH){1'b0}}, ctrl_q};
  assign irq_o   = ctrl_q.ready & ctrl_q.ie;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH programmable timers on the OR-combined data bus;
// decodes addresses, fans out write enables and ORs the per-channel read data.
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned     BITS        = 32,
  parameter int unsigned     NUM_CH      = 4,
  parameter logic [BITS-1:0] BASE        = 32'hF000_0020,
  parameter int unsigned     CH_STRIDE   = 16,
  parameter int unsigned     TICK_CYCLES = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [BITS-1:0]   memAddr,
  input  logic [BITS-1:0]   dataBusIn,
  output logic [BITS-1:0]   dataBusOut,
  output logic [NUM_CH-1:0] irq
);

  logic [NUM_CH-1:0][BITS-1:0] rd_data;
  logic                        aligned;

  assign aligned = (memAddr[1:0] == 2'b00);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [BITS-1:0] AddrCount = BASE + BITS'(c * CH_STRIDE + OFF_COUNT);
    localparam logic [BITS-1:0] AddrLimit = BASE + BITS'(c * CH_STRIDE + OFF_LIMIT);
    localparam logic [BITS-1:0] AddrCtrl  = BASE + BITS'(c * CH_STRIDE + OFF_CTRL);

    reg_sel_e        sel;
    logic [BITS-1:0] count, limit, ctrl;
    logic            ch_irq;

    always_comb begin
      sel = RegNone;
      if (aligned) begin
        if (memAddr == AddrCount) sel = RegCount;
        else if (memAddr == AddrLimit) sel = RegLimit;
        else if (memAddr == AddrCtrl) sel = RegCtrl;
      end
    end

    timer_channel #(
      .BITS        (BITS),
      .TICK_CYCLES (TICK_CYCLES)
    ) u_channel (
      .clk_i      (clk),
      .rst_ni     (reset),
      .we_count_i (we && (sel == RegCount)),
      .we_limit_i (we && (sel == RegLimit)),
      .we_ctrl_i  (we && (sel == RegCtrl)),
      .wdata_i    (dataBusIn),
      .count_o    (count),
      .limit_o    (limit),
      .ctrl_o     (ctrl),
      .irq_o      (ch_irq)
    );

    assign rd_data[c] = !re               ? '0    :
                        (sel == RegCount) ? count :
                        (sel == RegLimit) ? limit :
                        (sel == RegCtrl)  ? ctrl  : '0;

    assign irq[c] = ch_irq;
  end

  // Unaddressed channels contribute zero, so the OR is the selected register.
  always_comb begin
    dataBusOut = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dataBusOut = dataBusOut | rd_data[i];
    end
  end

  logic unused_decode;
  assign unused_decode = ^decode_offset(OFF_COUNT);

endmodule
